// File: rtl/light_pkg.sv
// light_pkg: shared widths, FSM state type and default timing constants for the light step sequencer.
package light_pkg;
  localparam int LEVEL_W = 3;
  localparam int TIMER_W = 32;
  localparam int LEVEL_MAX_D = 4;
  localparam int LEVEL_INIT_D = 2;
  localparam int REPEAT_CYCLES_D = 50_000_000;
  localparam int AUTO_STEP_CYCLES_D = 25_000_000;
  localparam int MANUAL_GUARD_D = 100_000_000;
  typedef enum logic [1:0] {IDLE, MAN_HOLD, GUARD, AUTO_SEEK} state_t;
endpackage

// File: rtl/light_step_timer.sv
// light_step_timer: reloadable down-counter; clear beats load beats enable, stops at zero.
module light_step_timer
  import light_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero,
  output logic         o_expire
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
  assign o_expire = r_cnt == W'(1);
endmodule

// File: rtl/light_step_sequencer.sv
// light_step_sequencer: arbitrates buttons and auto-seek into up/down pulses for a saturating level counter.
// Optional limit_hit output enabled by defining LIGHT_SEQ_LIMIT_FLAG_EN.
module light_step_sequencer
  import light_pkg::*;
#(
  parameter int LEVEL_MAX = LEVEL_MAX_D,
  parameter int LEVEL_INIT = LEVEL_INIT_D,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_D,
  parameter int AUTO_STEP_CYCLES = AUTO_STEP_CYCLES_D,
  parameter int MANUAL_GUARD = MANUAL_GUARD_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               auto_en,
  input  logic [LEVEL_W-1:0] auto_target,
  output logic               up_count,
  output logic               down_count,
  output logic [LEVEL_W-1:0] level,
`ifdef LIGHT_SEQ_LIMIT_FLAG_EN
  output logic               limit_hit,
`endif
  output logic               busy
);
  localparam logic [LEVEL_W-1:0] L_MAX = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] L_INIT = LEVEL_W'(LEVEL_INIT);
  localparam logic [TIMER_W-1:0] T_REP = TIMER_W'(REPEAT_CYCLES);
  localparam logic [TIMER_W-1:0] T_AUTO = TIMER_W'(AUTO_STEP_CYCLES);
  localparam logic [TIMER_W-1:0] T_GUARD = TIMER_W'(MANUAL_GUARD);
  state_t r_state, w_nxt;
  logic r_up, r_dn, r_dir, r_busy, r_up_prev, r_dn_prev, r_hist_vld;
  logic [LEVEL_W-1:0] r_level, w_lvl, w_tgt;
  logic w_up, w_dn, w_dir, w_up_press, w_dn_press, w_press, w_hold, w_up_ok, w_dn_ok;
  logic w_step_load, w_step_en, w_step_clr, w_step_exp, w_step_zero, w_step_fire;
  logic w_guard_load, w_guard_en, w_guard_clr, w_guard_exp, w_guard_zero;
  logic [TIMER_W-1:0] w_step_val;
  // Level as the counter will see it after any pulse currently on the wire.
  assign w_lvl = (r_up && r_level != L_MAX) ? r_level + 1'b1 :
                 (r_dn && r_level != '0) ? r_level - 1'b1 : r_level;
  assign w_tgt = auto_target > L_MAX ? L_MAX : auto_target;
  assign w_up_ok = w_lvl < L_MAX;
  assign w_dn_ok = w_lvl != '0;
  // History is invalid for the first cycle after reset so a button held through reset is not a press.
  assign w_up_press = r_hist_vld & btn_up & ~btn_down & ~r_up_prev;
  assign w_dn_press = r_hist_vld & btn_down & ~btn_up & ~r_dn_prev;
  assign w_press = w_up_press | w_dn_press;
  assign w_hold = (btn_up ^ btn_down) & (r_dir ? btn_up : btn_down);
  assign w_step_fire = w_step_exp | w_step_zero;
  assign w_step_val = w_nxt == AUTO_SEEK ? T_AUTO : T_REP;
  always_comb begin
    w_nxt = r_state;
    w_up = 1'b0;
    w_dn = 1'b0;
    w_dir = r_dir;
    w_step_load = 1'b0;
    w_step_en = 1'b0;
    w_step_clr = 1'b0;
    w_guard_load = 1'b0;
    w_guard_en = 1'b0;
    w_guard_clr = 1'b0;
    if (!on) begin
      w_nxt = IDLE;
      w_step_clr = 1'b1;
      w_guard_clr = 1'b1;
    end else if (w_press) begin
      w_nxt = MAN_HOLD;
      w_dir = w_up_press;
      w_up = w_up_press & w_up_ok;
      w_dn = w_dn_press & w_dn_ok;
      w_step_load = 1'b1;
      w_guard_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (auto_en && w_guard_zero && w_tgt != w_lvl) begin
          w_nxt = AUTO_SEEK;
          w_up = w_tgt > w_lvl;
          w_dn = w_tgt < w_lvl;
          w_step_load = 1'b1;
        end
        MAN_HOLD: if (!w_hold) begin
          w_nxt = GUARD;
          w_guard_load = 1'b1;
          w_step_clr = 1'b1;
        end else if (w_step_fire) begin
          w_up = r_dir & w_up_ok;
          w_dn = ~r_dir & w_dn_ok;
          w_step_load = 1'b1;
        end else w_step_en = 1'b1;
        GUARD: begin
          w_guard_en = 1'b1;
          w_nxt = (w_guard_exp || w_guard_zero) ? IDLE : GUARD;
        end
        AUTO_SEEK: if (!auto_en || w_tgt == w_lvl) begin
          w_nxt = IDLE;
          w_step_clr = 1'b1;
        end else if (w_step_fire) begin
          w_up = w_tgt > w_lvl;
          w_dn = w_tgt < w_lvl;
          w_step_load = 1'b1;
        end else w_step_en = 1'b1;
        default: w_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_up <= 1'b0;
      r_dn <= 1'b0;
      r_dir <= 1'b0;
      r_busy <= 1'b0;
      r_up_prev <= 1'b0;
      r_dn_prev <= 1'b0;
      r_hist_vld <= 1'b0;
      r_level <= L_INIT;
    end else begin
      r_state <= w_nxt;
      r_up <= w_up;
      r_dn <= w_dn;
      r_dir <= w_dir;
      r_busy <= w_nxt != IDLE;
      r_up_prev <= btn_up;
      r_dn_prev <= btn_down;
      r_hist_vld <= 1'b1;
      r_level <= on ? w_lvl : r_level;
    end
  light_step_timer #(.W(TIMER_W)) u_step (
    .clk(clk), .rst(rst), .i_clr(w_step_clr), .i_load(w_step_load), .i_load_val(w_step_val),
    .i_en(w_step_en), .o_zero(w_step_zero), .o_expire(w_step_exp)
  );
  light_step_timer #(.W(TIMER_W)) u_guard (
    .clk(clk), .rst(rst), .i_clr(w_guard_clr), .i_load(w_guard_load), .i_load_val(T_GUARD),
    .i_en(w_guard_en), .o_zero(w_guard_zero), .o_expire(w_guard_exp)
  );
`ifdef LIGHT_SEQ_LIMIT_FLAG_EN
  logic r_lim, w_lim;
  // Flags a manual press or repeat that was swallowed because the level sits at a bound.
  assign w_lim = on & (w_press ? (w_up_press ? ~w_up_ok : ~w_dn_ok) :
                 (r_state == MAN_HOLD) & w_hold & w_step_fire & (r_dir ? ~w_up_ok : ~w_dn_ok));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_lim <= 1'b0;
    else r_lim <= w_lim;
  assign limit_hit = r_lim;
`endif
  assign up_count = r_up;
  assign down_count = r_dn;
  assign level = r_level;
  assign busy = r_busy;
endmodule

// File: tb/tb_light_step_sequencer.sv
// tb_light_step_sequencer: table-driven directed checks plus an async-reset-during-hold sequence.
module tb_light_step_sequencer;
  logic clk = 1'b0, rst = 1'b1, on = 1'b0, btn_up = 1'b0, btn_down = 1'b0, auto_en = 1'b0;
  logic [2:0] auto_target = 3'd0;
  logic up_count, down_count, busy;
  logic [2:0] level;
`ifdef LIGHT_SEQ_LIMIT_FLAG_EN
  logic limit_hit;
`endif
  int errors = 0, checks = 0;
  typedef struct {
    logic rst, on, up, dn, aen;
    logic [2:0] tgt;
    logic eu, ed;
    logic [2:0] el;
    logic eb, elim;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  light_step_sequencer #(
    .LEVEL_MAX(4), .LEVEL_INIT(2), .REPEAT_CYCLES(4), .AUTO_STEP_CYCLES(3), .MANUAL_GUARD(8)
  ) dut (
    .clk(clk), .rst(rst), .on(on), .btn_up(btn_up), .btn_down(btn_down), .auto_en(auto_en),
    .auto_target(auto_target), .up_count(up_count), .down_count(down_count), .level(level),
`ifdef LIGHT_SEQ_LIMIT_FLAG_EN
    .limit_hit(limit_hit),
`endif
    .busy(busy)
  );
  task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask
  function automatic void add(input int n, input logic r, o, u, d, a, input logic [2:0] t,
                              input logic eu, ed, input logic [2:0] el, input logic eb, input logic elim = 1'b0);
    vec_t v;
    v = '{rst: r, on: o, up: u, dn: d, aen: a, tgt: t, eu: eu, ed: ed, el: el, eb: eb, elim: elim};
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction
  initial begin
    // reset + idle, then single tap: pulse, level 2->3, 8 guard cycles
    add(1, 1,1,0,0,0,3'd0, 0,0,3'd2,0);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd2,0);
    add(1, 0,1,1,0,0,3'd0, 1,0,3'd2,1);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd3,1);
    add(7, 0,1,0,0,0,3'd0, 0,0,3'd3,1);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd3,0);
    // auto seek down 3->0 every 3 cycles
    add(1, 0,1,0,0,1,3'd0, 0,1,3'd3,1);
    add(2, 0,1,0,0,1,3'd0, 0,0,3'd2,1);
    add(1, 0,1,0,0,1,3'd0, 0,1,3'd2,1);
    add(2, 0,1,0,0,1,3'd0, 0,0,3'd1,1);
    add(1, 0,1,0,0,1,3'd0, 0,1,3'd1,1);
    add(1, 0,1,0,0,1,3'd0, 0,0,3'd0,0);
    // auto target 7 clamps to 4
    add(1, 0,1,0,0,1,3'd7, 1,0,3'd0,1);
    add(2, 0,1,0,0,1,3'd7, 0,0,3'd1,1);
    add(1, 0,1,0,0,1,3'd7, 1,0,3'd1,1);
    add(2, 0,1,0,0,1,3'd7, 0,0,3'd2,1);
    add(1, 0,1,0,0,1,3'd7, 1,0,3'd2,1);
    add(2, 0,1,0,0,1,3'd7, 0,0,3'd3,1);
    add(1, 0,1,0,0,1,3'd7, 1,0,3'd3,1);
    add(1, 0,1,0,0,1,3'd7, 0,0,3'd4,0);
    add(1, 0,1,0,0,0,3'd7, 0,0,3'd4,0);
    // held up 20 cycles from 2: pulses at 0 and 4, dropped repeats at 8, 12, 16
    add(1, 1,1,0,0,0,3'd0, 0,0,3'd2,0);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd2,0);
    add(1, 0,1,1,0,0,3'd0, 1,0,3'd2,1);
    add(3, 0,1,1,0,0,3'd0, 0,0,3'd3,1);
    add(1, 0,1,1,0,0,3'd0, 1,0,3'd3,1);
    add(3, 0,1,1,0,0,3'd0, 0,0,3'd4,1);
    add(1, 0,1,1,0,0,3'd0, 0,0,3'd4,1,1'b1);
    add(3, 0,1,1,0,0,3'd0, 0,0,3'd4,1);
    add(1, 0,1,1,0,0,3'd0, 0,0,3'd4,1,1'b1);
    add(3, 0,1,1,0,0,3'd0, 0,0,3'd4,1);
    add(1, 0,1,1,0,0,3'd0, 0,0,3'd4,1,1'b1);
    add(3, 0,1,1,0,0,3'd0, 0,0,3'd4,1);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd4,1);
    // manual press preempts auto seek; auto blocked through guard
    add(1, 1,1,0,0,0,3'd0, 0,0,3'd2,0);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd2,0);
    add(1, 0,1,0,0,1,3'd0, 0,1,3'd2,1);
    add(1, 0,1,1,0,1,3'd0, 1,0,3'd1,1);
    add(1, 0,1,0,0,1,3'd0, 0,0,3'd2,1);
    add(7, 0,1,0,0,1,3'd0, 0,0,3'd2,1);
    add(1, 0,1,0,0,1,3'd0, 0,0,3'd2,0);
    add(1, 0,1,0,0,1,3'd0, 0,1,3'd2,1);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd1,0);
    // both buttons together, on=0 press, button held across on rising
    add(2, 0,1,1,1,0,3'd0, 0,0,3'd1,0);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd1,0);
    add(1, 0,0,1,0,0,3'd0, 0,0,3'd1,0);
    add(1, 0,0,0,0,0,3'd0, 0,0,3'd1,0);
    add(1, 0,0,1,0,0,3'd0, 0,0,3'd1,0);
    add(1, 0,1,1,0,0,3'd0, 0,0,3'd1,0);
    add(1, 0,1,0,0,0,3'd0, 0,0,3'd1,0);
    @(posedge clk); #1;
    chk("reset_up", -1, {2'b0, up_count}, 3'd0);
    chk("reset_down", -1, {2'b0, down_count}, 3'd0);
    chk("reset_level", -1, level, 3'd2);
    chk("reset_busy", -1, {2'b0, busy}, 3'd0);
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; on = vq[i].on; btn_up = vq[i].up; btn_down = vq[i].dn;
      auto_en = vq[i].aen; auto_target = vq[i].tgt;
      @(posedge clk); #1;
      chk("up_count", i, {2'b0, up_count}, {2'b0, vq[i].eu});
      chk("down_count", i, {2'b0, down_count}, {2'b0, vq[i].ed});
      chk("level", i, level, vq[i].el);
      chk("busy", i, {2'b0, busy}, {2'b0, vq[i].eb});
`ifdef LIGHT_SEQ_LIMIT_FLAG_EN
      chk("limit_hit", i, {2'b0, limit_hit}, {2'b0, vq[i].elim});
`endif
    end
    // async reset during a hold at level 4, button kept down afterwards
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    btn_up = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("hold_level", 1000, level, 3'd4);
    chk("hold_busy", 1000, {2'b0, busy}, 3'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_up", 1001, {2'b0, up_count}, 3'd0);
    chk("async_rst_down", 1001, {2'b0, down_count}, 3'd0);
    chk("async_rst_level", 1001, level, 3'd2);
    chk("async_rst_busy", 1001, {2'b0, busy}, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_up", 1002 + i, {2'b0, up_count}, 3'd0);
      chk("post_rst_busy", 1002 + i, {2'b0, busy}, 3'd0);
    end
    chk("post_rst_level", 1010, level, 3'd2);
    btn_up = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/light_step_sequencer.md
Name: light_step_sequencer

Overview:
- Controller for the 3-bit saturating light-level counter (range 0..LEVEL_MAX, reset level LEVEL_INIT).
- Arbitrates two requesters, manual buttons and an automatic ambient-target seeker, into single-cycle up_count/down_count pulses for that counter.
- Keeps a mirror of the counter level so no pulse is issued that the counter would discard at a bound.
- Sits between the button/sensor front end and the counter; its on input is the same enable the counter receives.

Parameters:
- LEVEL_MAX, 4, top level of the counter (1..7).
- LEVEL_INIT, 2, counter reset level; mirror reset value.
- REPEAT_CYCLES, 50_000_000, held-button auto-repeat period in clk cycles (>=2).
- AUTO_STEP_CYCLES, 25_000_000, spacing between auto-seek pulses (>=2).
- MANUAL_GUARD, 100_000_000, cycles after button release during which auto requests are ignored (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- on  in  1  system enable; 0 suppresses all pulses
- btn_up  in  1  up button level, already synchronised/debounced
- btn_down  in  1  down button level, already synchronised/debounced
- auto_en  in  1  enables auto-seek requester
- auto_target  in  3  desired level from ambient logic
- up_count  out  1  single-cycle increment pulse to counter
- down_count  out  1  single-cycle decrement pulse to counter
- level  out  3  mirror of counter value
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1, async): state=IDLE; level=LEVEL_INIT; up_count=down_count=busy=0; all timers 0; button history 0. Reset mid-hold or mid-seek aborts with no further pulses.
- All outputs are registered. up_count and down_count are never high together and are each exactly 1 cycle wide.
- level updates at the clock edge that ends a pulse, saturating 0..LEVEL_MAX. It equals the counter value every cycle.
- Manual press = rising edge of exactly one button (btn_up XOR btn_down high and previously low). Both buttons high = no request.
- Manual latency: a press sampled at edge k drives the pulse high from edge k to edge k+1. A press at a bound (up at LEVEL_MAX, down at 0) issues no pulse but still enters MAN_HOLD.
- States:
  - IDLE -> MAN_HOLD on a manual press (pulse if allowed; repeat timer=REPEAT_CYCLES).
  - IDLE -> AUTO_SEEK when on & auto_en & guard==0 & clamp(auto_target)!=level, where clamp() limits to LEVEL_MAX. The first pulse toward the target is issued at entry.
  - MAN_HOLD: the timer decrements; at expiry (timer==1) issue another pulse in the same direction if not at a bound, then reload. On release, or when both buttons go high, go to GUARD with guard=MANUAL_GUARD.
  - GUARD: the guard timer counts down. A new manual press goes to MAN_HOLD. Guard reaching 0 -> IDLE.
  - AUTO_SEEK: issue one pulse every AUTO_STEP_CYCLES toward clamp(auto_target); the target is re-sampled every cycle. Reaching target, or auto_en=0 -> IDLE.
- Manual press in AUTO_SEEK preempts that same cycle. The manual pulse is issued and the auto pulse is dropped.
- on=0: no pulses; state -> IDLE; timers cleared; level held. Button history still tracks, so a button held across on rising does not register as a press.

Optional Feature:
- Macro LIGHT_SEQ_LIMIT_FLAG_EN.
- Defined: adds output limit_hit (1 bit). It pulses for 1 cycle, aligned with where the pulse would have been, whenever a manual press or repeat is dropped at a bound. Reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package light_pkg: LEVEL_W=3; state enum {IDLE, MAN_HOLD, GUARD, AUTO_SEEK}; default parameter constants.
- One sub-module, light_step_timer: reloadable down-counter with load, enable, clear and expire outputs. Instantiated twice: once for repeat/auto-step, once for the guard.

Test Plan (LEVEL_MAX=4, LEVEL_INIT=2, REPEAT_CYCLES=4, AUTO_STEP_CYCLES=3, MANUAL_GUARD=8):
- Reset, on=1, btn_up pulsed high 1 cycle -> one up_count pulse 1 cycle after sampling; level 2->3; GUARD for 8 cycles, then IDLE.
- btn_up held 20 cycles from level 2 -> pulses at offsets 0, 4 (level 4). Later expiries give no pulse; level stays 4. With LIGHT_SEQ_LIMIT_FLAG_EN, limit_hit pulses at offsets 8, 12, 16.
- auto_en=1, auto_target=0, level 3, guard 0 -> down_count at 0, 3, 6; level 0; IDLE. auto_target=7 then seeks up to 4 only.
- During AUTO_SEEK, btn_up press -> up_count that cycle, no down_count, state MAN_HOLD; auto ignored until guard expires.
- btn_up and btn_down rise together -> no pulses, state stays IDLE. Also check on=0 with a button press -> no pulses, level unchanged.
- rst asserted mid-MAN_HOLD at level 4 -> outputs 0 immediately, level=2, IDLE; with the button still held after release of reset, no pulse.
